sum_accumulator: RTL

//  Downstream stage of the 4-bit adder (fba). Consumes each {Carry,Sum} result (0..30)

---
 rtl/sum_accumulator.sv | 118 +++++++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: accepts {Carry,Sum} adder results over a valid/ready
// handshake and sums N_SAMPLES of them into an ACC_W-bit total. The total
// is presented with done and held until result_ack.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; in_ready=0, done=0, last total held
// RUN   | accepting beats; in_ready=1 until N_SAMPLES are taken
// DONE  | total final and frozen; done=1 until result_ack
module sum_accumulator #(
   parameter int ACC_W     = 12,
   parameter int N_SAMPLES = 16,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Sum,
   input  logic             Carry,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             done,
   input  logic             result_ack
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

   state_t           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             done_q;
   logic             in_ready_q;

   logic [ACC_W:0]   sum_d;
   logic [CNT_W-1:0] cnt_d;
   logic             accept;
   logic             last_beat;

   // One extra bit on the adder captures the wrap out of bit ACC_W-1.
   always_comb begin
      sum_d     = {1'b0, acc_q} + (ACC_W+1)'({Carry, Sum});
      cnt_d     = cnt_q + CNT_W'(1);
      accept    = in_valid & in_ready_q;
      last_beat = (cnt_d == N_CNT);
   end

   // Sequencer with registered handshake/status outputs; clear overrides any transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else if (clear) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= RUN;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  ovf_q      <= 1'b0;
                  in_ready_q <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  acc_q <= sum_d[ACC_W-1:0];
                  cnt_q <= cnt_d;
                  if (sum_d[ACC_W]) ovf_q <= 1'b1;
                  if (last_beat) begin
                     state_q    <= DONE;
                     in_ready_q <= 1'b0;
                     done_q     <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (result_ack) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               done_q     <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign acc_out  = acc_q;
   assign count    = cnt_q;
   assign overflow = ovf_q;
   assign done     = done_q;

endmodule
